conv_fmap_writer: RTL and testbench

//  Consumer end of a conv layer's result stream (8-bit result + valid, channel-major, then row, then col).

---
 rtl/fmap_pkg.sv | 25 ++
 rtl/conv_fmap_writer_if.sv | 28 ++
 rtl/conv_fmap_writer.sv | 134 +++++++++++++
 tb/tb_conv_fmap_writer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fmap_pkg.sv
// rtl/fmap_pkg.sv - shared feature-map geometry helpers and types for the conv layer chain
package fmap_pkg;

    localparam int SAMPLE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_STREAM = 2'd2
    } fmap_state_t;

    function automatic int padded_dim(input int n, input int pad);
        return n + 2 * pad;
    endfunction

    function automatic int map_size(input int ch, input int h, input int w);
        return ch * h * w;
    endfunction

    // Counter width for a bound, never below one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_fmap_writer_if.sv
// rtl/conv_fmap_writer_if.sv - result stream in, padded feature-map RAM write port out
interface conv_fmap_writer_if #(
    parameter int AW = 6
);
    import fmap_pkg::*;

    logic                start;
    logic [SAMPLE_W-1:0] in_data;
    logic                in_valid;
    logic                ready;
    logic                busy;
    logic                done;
    logic                err_overflow;
    logic [SAMPLE_W-1:0] out_data;
    logic                out_we;
    logic [AW-1:0]       out_addr;

    modport slave (
        input  start, in_data, in_valid,
        output ready, busy, done, err_overflow, out_data, out_we, out_addr
    );

    modport master (
        output start, in_data, in_valid,
        input  ready, busy, done, err_overflow, out_data, out_we, out_addr
    );

endinterface

// File: rtl/conv_fmap_writer.sv
// rtl/conv_fmap_writer.sv - zero-fills the padded next-layer map, then scatters conv results into its interior
module conv_fmap_writer
    import fmap_pkg::*;
#(
    parameter int CHANNELS  = 32,
    parameter int IN_WIDTH  = 28,
    parameter int IN_HEIGHT = 28,
    parameter int PAD       = 1
) (
    input  logic              clk,
    input  logic              rstn,
    conv_fmap_writer_if.slave bus
);

    localparam int PW       = padded_dim(IN_WIDTH, PAD);
    localparam int PH       = padded_dim(IN_HEIGHT, PAD);
    localparam int MAP_SIZE = map_size(CHANNELS, PH, PW);
    localparam int AW       = $clog2(MAP_SIZE);
    localparam int CW       = cnt_w(IN_WIDTH);
    localparam int RW       = cnt_w(IN_HEIGHT);
    localparam int CHW      = cnt_w(CHANNELS);
    localparam int FIRST    = PAD * PW + PAD;
    localparam int STEP_ROW = 2 * PAD + 1;
    localparam int STEP_CH  = 2 * PAD * PW + 2 * PAD + 1;

    fmap_state_t         state_q;
    logic [AW-1:0]       addr_q, addr_d;
    logic [CW-1:0]       col_q;
    logic [RW-1:0]       row_q;
    logic [CHW-1:0]      ch_q;
    logic                out_we_q;
    logic [SAMPLE_W-1:0] out_data_q;
    logic [AW-1:0]       out_addr_q;
    logic                last_wr_q;
    logic                done_q;
    logic                err_q;
    logic                last_col, last_row, last_ch;

    // The cursor skips the right/left border pair at row ends and the bottom/top border rows at channel ends.
    always_comb begin
        last_col = (col_q == CW'(IN_WIDTH - 1));
        last_row = (row_q == RW'(IN_HEIGHT - 1));
        last_ch  = (ch_q == CHW'(CHANNELS - 1));
        addr_d   = addr_q + AW'(1);
        if (last_col && !last_row) begin
            addr_d = addr_q + AW'(STEP_ROW);
        end else if (last_col && last_row) begin
            addr_d = addr_q + AW'(STEP_CH);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            ch_q       <= '0;
            out_we_q   <= 1'b0;
            out_data_q <= '0;
            out_addr_q <= '0;
            last_wr_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            out_we_q  <= 1'b0;
            last_wr_q <= 1'b0;
            done_q    <= last_wr_q;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        err_q      <= 1'b0;
                        out_addr_q <= '0;
                        out_data_q <= '0;
                        out_we_q   <= 1'b1;
                        state_q    <= ST_CLEAR;
                    end else if (bus.in_valid) begin
                        err_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (bus.in_valid) begin
                        err_q <= 1'b1;
                    end
                    if (out_addr_q == AW'(MAP_SIZE - 1)) begin
                        addr_q  <= AW'(FIRST);
                        col_q   <= '0;
                        row_q   <= '0;
                        ch_q    <= '0;
                        state_q <= ST_STREAM;
                    end else begin
                        out_addr_q <= out_addr_q + AW'(1);
                        out_data_q <= '0;
                        out_we_q   <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (bus.in_valid) begin
                        out_we_q   <= 1'b1;
                        out_data_q <= bus.in_data;
                        out_addr_q <= addr_q;
                        addr_q     <= addr_d;
                        if (!last_col) begin
                            col_q <= col_q + CW'(1);
                        end else begin
                            col_q <= '0;
                            if (!last_row) begin
                                row_q <= row_q + RW'(1);
                            end else begin
                                row_q <= '0;
                                ch_q  <= ch_q + CHW'(1);
                            end
                        end
                        // Leave STREAM as the final write issues so nothing after it is mistaken for data.
                        if (last_col && last_row && last_ch) begin
                            last_wr_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready        = (state_q == ST_STREAM);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.done         = done_q;
    assign bus.err_overflow = err_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_we       = out_we_q;
    assign bus.out_addr     = out_addr_q;

endmodule

// File: tb/tb_conv_fmap_writer.sv
// tb/tb_conv_fmap_writer.sv - self-checking bench for conv_fmap_writer on a 2x2x3 map with PAD=1
module tb_conv_fmap_writer;
    import fmap_pkg::*;

    localparam int CHANNELS  = 2;
    localparam int IN_WIDTH  = 3;
    localparam int IN_HEIGHT = 2;
    localparam int PAD       = 1;
    localparam int PW        = IN_WIDTH + 2 * PAD;
    localparam int PH        = IN_HEIGHT + 2 * PAD;
    localparam int MAP_SIZE  = CHANNELS * PH * PW;
    localparam int NSAMP     = CHANNELS * IN_HEIGHT * IN_WIDTH;
    localparam int AW        = $clog2(MAP_SIZE);

    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    int   wr_addr[$];
    int   wr_data[$];
    int   wr_cyc[$];
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic done_busy = 1'b0;
    logic done_ready = 1'b0;

    conv_fmap_writer_if #(.AW(AW)) bus ();

    conv_fmap_writer #(
        .CHANNELS (CHANNELS),
        .IN_WIDTH (IN_WIDTH),
        .IN_HEIGHT(IN_HEIGHT),
        .PAD      (PAD)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_we) begin
            wr_addr.push_back(int'(bus.out_addr));
            wr_data.push_back(int'(bus.out_data));
            wr_cyc.push_back(cyc);
        end
        if (bus.done) begin
            done_cnt   <= done_cnt + 1;
            done_cyc   <= cyc;
            done_busy  <= bus.busy;
            done_ready <= bus.ready;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_we"},    32'(bus.out_we), 0);
        chk({tag, "_addr"},  32'(bus.out_addr), 0);
        chk({tag, "_data"},  32'(bus.out_data), 0);
        chk({tag, "_done"},  32'(bus.done), 0);
        chk({tag, "_busy"},  32'(bus.busy), 0);
        chk({tag, "_ready"}, 32'(bus.ready), 0);
        chk({tag, "_err"},   32'(bus.err_overflow), 0);
    endtask

    // One frame: start, verify the zero fill, stream random samples, verify placement and done.
    task automatic run_frame(input int gap, input int ovf_at, input int start_at, input int rst_at);
        int b;
        int dbase;
        int k;
        int exp_a[$];
        int exp_d[$];
        int vcyc[$];
        logic [7:0] d;

        b     = wr_addr.size();
        dbase = done_cnt;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4 * MAP_SIZE; i++) begin
            if (i == ovf_at) begin
                bus.in_data  = 8'hAA;
                bus.in_valid = 1'b1;
            end
            step();
            bus.in_valid = 1'b0;
            if (bus.ready) break;
        end
        chk("ready_after_clear", 32'(bus.ready), 1);
        chk("busy_after_clear", 32'(bus.busy), 1);
        chk("clear_write_count", 32'(wr_addr.size() - b), MAP_SIZE);
        for (int i = 0; i < MAP_SIZE; i++) begin
            if (b + i < wr_addr.size()) begin
                chk("clear_addr", 32'(wr_addr[b + i]), 32'(i));
                chk("clear_data", 32'(wr_data[b + i]), 0);
                chk("clear_cycle", 32'(wr_cyc[b + i] - wr_cyc[b]), 32'(i));
            end
        end
        chk("err_after_clear", 32'(bus.err_overflow), (ovf_at >= 0) ? 1 : 0);

        b = wr_addr.size();
        k = 0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            for (int r = 0; r < IN_HEIGHT; r++) begin
                for (int c = 0; c < IN_WIDTH; c++) begin
                    d = 8'($urandom_range(1, 255));
                    exp_a.push_back(ch * PH * PW + (r + PAD) * PW + (c + PAD));
                    exp_d.push_back(int'(d));
                    vcyc.push_back(cyc);
                    bus.in_data  = d;
                    bus.in_valid = 1'b1;
                    if (k == start_at) bus.start = 1'b1;
                    step();
                    bus.in_valid = 1'b0;
                    bus.start    = 1'b0;
                    if (k == rst_at) begin
                        rstn = 1'b0;
                        #1;
                        chk_outputs_zero("async_reset");
                        step();
                        rstn = 1'b1;
                        step();
                        return;
                    end
                    repeat (gap - 1) step();
                    k++;
                end
            end
        end

        for (int i = 0; i < 20 && done_cnt == dbase; i++) step();
        repeat (6) step();
        chk("done_count", 32'(done_cnt - dbase), 1);
        chk("done_busy", 32'(done_busy), 0);
        chk("done_ready", 32'(done_ready), 0);
        chk("stream_write_count", 32'(wr_addr.size() - b), NSAMP);
        for (int i = 0; i < NSAMP; i++) begin
            if (b + i < wr_addr.size()) begin
                chk("stream_addr", 32'(wr_addr[b + i]), 32'(exp_a[i]));
                chk("stream_data", 32'(wr_data[b + i]), 32'(exp_d[i]));
                chk("stream_we_latency", 32'(wr_cyc[b + i]), 32'(vcyc[i] + 1));
            end
        end
        if (wr_addr.size() - b == NSAMP) begin
            chk("done_after_last_write", 32'(done_cyc), 32'(wr_cyc[b + NSAMP - 1] + 1));
        end
        chk("idle_busy", 32'(bus.busy), 0);
        chk("err_sticky", 32'(bus.err_overflow), (ovf_at >= 0) ? 1 : 0);
    endtask

    initial begin
        rstn         = 1'b0;
        bus.start    = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        step();
        step();
        chk_outputs_zero("reset");
        rstn = 1'b1;
        step();

        run_frame(3, -1, -1, -1);
        run_frame(1, -1, -1, -1);
        run_frame(2, 5, -1, -1);
        run_frame(1, -1, -1, 4);
        run_frame(2, -1, -1, -1);
        run_frame(1, -1, 6, -1);
        run_frame(int'($urandom_range(1, 4)), -1, int'($urandom_range(0, NSAMP - 1)), -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
